// File: rtl/eda_local_max_stream.sv
// -----------------------------------------------------------------------------
// eda_local_max_stream
//
// Streaming local-maximum detector. An M x N frame arrives as a raster-order
// pixel stream. One flag per pixel leaves in raster order, and the flag is 1
// when that pixel is a local maximum of its in-frame neighbourhood.
//
// The block holds no frame buffer. A shift register keeps the last 2N+2
// accepted pixels. Together with the pixel being accepted, that register spans
// the full 3x3 window around the pixel N+1 positions back in the stream.
//
// Ports
//   clk, reset_n        clock and asynchronous active-low reset
//   start               one-cycle pulse that begins a frame (ignored while busy)
//   mode_8conn          1 = 8-neighbour window, 0 = 4-neighbour (latched at start)
//   mode_strict         1 = strictly greater, 0 = greater-or-equal (latched at start)
//   in_valid/in_ready   input pixel handshake
//   pixel_in            raster-order pixel
//   out_valid/out_ready output flag handshake, with backpressure
//   out_max             local-maximum flag
//   out_last            marks the flag of pixel (M-1, N-1)
//   done                one-cycle pulse after out_last has been handshaken
//   max_count           number of maxima in the last completed frame
//   busy                high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module eda_local_max_stream #(
  parameter int M           = 8,
  parameter int N           = 8,
  parameter int PIXEL_WIDTH = 8,
  parameter int CNT_WIDTH   = $clog2(M*N+1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   mode_8conn,
  input  logic                   mode_strict,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PIXEL_WIDTH-1:0] pixel_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_max,
  output logic                   out_last,
  output logic                   done,
  output logic [CNT_WIDTH-1:0]   max_count,
  output logic                   busy
);

  localparam int TOTAL = M * N;
  localparam int IDX_W = $clog2(TOTAL + 1);
  localparam int ROW_W = $clog2(M);
  localparam int COL_W = $clog2(N);
  localparam int HIST  = 2 * N + 2;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TOTAL - 1);
  localparam logic [IDX_W-1:0] FIRST_EMIT = IDX_W'(N + 1);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(M - 1);
  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic                   mode_8_q;
  logic                   mode_strict_q;
  logic [IDX_W-1:0]       in_idx;
  logic [ROW_W-1:0]       flag_row;
  logic [COL_W-1:0]       flag_col;
  logic                   last_loaded;
  logic [CNT_WIDTH-1:0]   cnt_acc;
  logic [PIXEL_WIDTH-1:0] hist [HIST];

  logic                   out_free;
  logic                   out_hs;
  logic                   accept;
  logic                   load_stream;
  logic                   load_flush;
  logic                   load_flag;
  logic                   shift_hist;
  logic [PIXEL_WIDTH-1:0] new_pixel;
  logic                   flag_val;
  logic                   flag_is_last;

  function automatic logic beats(input logic [PIXEL_WIDTH-1:0] a,
                                 input logic [PIXEL_WIDTH-1:0] b,
                                 input logic                   strict);
    return strict ? (a > b) : (a >= b);
  endfunction

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and FSM outputs. Input acceptance is tied to the output
  // register having room, so a stalled output also stalls the input.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          state_next = STREAM;
        end
      end
      STREAM: begin
        in_ready = out_free;
        if (in_valid && out_free && (in_idx == LAST_IDX)) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (out_hs && out_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake qualifiers. Once the input stops, the flush phase shifts a
  // dummy zero into the history. That keeps the window aligned for the last
  // N+1 flags. The dummy only ever lands in positions that the border masks
  // exclude for those flags.
  always_comb begin
    out_free    = !out_valid || out_ready;
    out_hs      = out_valid && out_ready;
    accept      = in_valid && in_ready;
    load_stream = accept && (in_idx >= FIRST_EMIT);
    load_flush  = (state == FLUSH) && out_free && !last_loaded;
    load_flag   = load_stream || load_flush;
    shift_hist  = accept || load_flush;
    new_pixel   = accept ? pixel_in : '0;
  end

  // Window evaluation for the centre pixel at (flag_row, flag_col).
  // hist[0] holds the pixel N positions after the centre, hist[N] holds the
  // centre itself, and hist[2N+1] holds its north-west neighbour. The
  // south-east neighbour is the pixel being accepted this cycle.
  always_comb begin
    logic                   has_n;
    logic                   has_s;
    logic                   has_w;
    logic                   has_e;
    logic [PIXEL_WIDTH-1:0] centre;
    has_n    = (flag_row != '0);
    has_s    = (flag_row != LAST_ROW);
    has_w    = (flag_col != '0);
    has_e    = (flag_col != LAST_COL);
    centre   = hist[N];
    flag_val = 1'b1;
    if (has_n && !beats(centre, hist[2*N], mode_strict_q)) flag_val = 1'b0;
    if (has_s && !beats(centre, hist[0], mode_strict_q)) flag_val = 1'b0;
    if (has_w && !beats(centre, hist[N+1], mode_strict_q)) flag_val = 1'b0;
    if (has_e && !beats(centre, hist[N-1], mode_strict_q)) flag_val = 1'b0;
    if (mode_8_q) begin
      if (has_n && has_w && !beats(centre, hist[2*N+1], mode_strict_q)) flag_val = 1'b0;
      if (has_n && has_e && !beats(centre, hist[2*N-1], mode_strict_q)) flag_val = 1'b0;
      if (has_s && has_w && !beats(centre, hist[1], mode_strict_q)) flag_val = 1'b0;
      if (has_s && has_e && !beats(centre, new_pixel, mode_strict_q)) flag_val = 1'b0;
    end
    flag_is_last = (flag_row == LAST_ROW) && (flag_col == LAST_COL);
  end

  // Frame control: latched modes, input index, and the coordinates of the
  // next flag to load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_8_q      <= 1'b0;
      mode_strict_q <= 1'b0;
      in_idx        <= '0;
      flag_row      <= '0;
      flag_col      <= '0;
      last_loaded   <= 1'b0;
    end else if ((state == IDLE) && start) begin
      mode_8_q      <= mode_8conn;
      mode_strict_q <= mode_strict;
      in_idx        <= '0;
      flag_row      <= '0;
      flag_col      <= '0;
      last_loaded   <= 1'b0;
    end else begin
      if (accept) begin
        in_idx <= in_idx + 1'b1;
      end
      if (load_flag) begin
        if (flag_is_last) begin
          last_loaded <= 1'b1;
        end else if (flag_col == LAST_COL) begin
          flag_col <= '0;
          flag_row <= flag_row + 1'b1;
        end else begin
          flag_col <= flag_col + 1'b1;
        end
      end
    end
  end

  // Pixel history shift register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < HIST; j++) begin
        hist[j] <= '0;
      end
    end else if (shift_hist) begin
      for (int j = HIST - 1; j > 0; j--) begin
        hist[j] <= hist[j-1];
      end
      hist[0] <= new_pixel;
    end
  end

  // Output register. It reloads only when it is empty or being drained, so a
  // stalled flag stays put until downstream takes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_max   <= 1'b0;
      out_last  <= 1'b0;
    end else if (out_free) begin
      out_valid <= load_flag;
      out_max   <= load_flag && flag_val;
      out_last  <= load_flag && flag_is_last;
    end
  end

  // Maxima counting. max_count changes only when a frame completes, so it
  // still shows the previous frame's result while a new frame is running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_acc   <= '0;
      max_count <= '0;
    end else if ((state == IDLE) && start) begin
      cnt_acc <= '0;
    end else if (out_hs) begin
      if (out_last) begin
        max_count <= cnt_acc + CNT_WIDTH'(out_max);
      end
      if (out_max) begin
        cnt_acc <= cnt_acc + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_eda_local_max_stream.sv
// -----------------------------------------------------------------------------
// tb_eda_local_max_stream
//
// Drives frames into eda_local_max_stream and collects every output flag. The
// collected flags are compared against a window-based reference computed
// directly from the frame contents.
// -----------------------------------------------------------------------------
module tb_eda_local_max_stream;

  localparam int M     = 4;
  localparam int N     = 4;
  localparam int PW    = 8;
  localparam int CW    = $clog2(M*N+1);
  localparam int TOTAL = M * N;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          mode_8conn = 1'b0;
  logic          mode_strict = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] pixel_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_max;
  logic          out_last;
  logic          done;
  logic [CW-1:0] max_count;
  logic          busy;

  eda_local_max_stream #(
    .M(M), .N(N), .PIXEL_WIDTH(PW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .mode_8conn(mode_8conn), .mode_strict(mode_strict),
    .in_valid(in_valid), .in_ready(in_ready), .pixel_in(pixel_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max),
    .out_last(out_last), .done(done), .max_count(max_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  logic [PW-1:0]    frame [TOTAL];
  logic [TOTAL-1:0] exp_flags;
  int               exp_cnt;
  logic [TOTAL-1:0] got_flags;
  logic [TOTAL-1:0] got_last;
  logic [TOTAL-1:0] saved_flags;
  int               n_flags;
  int               n_done;
  int               n_bad;
  bit               timed_out;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: scan each pixel's 3x3 window, skip positions outside the frame
  // (and diagonals in 4-neighbour mode), then compare with plain arithmetic.
  task automatic modelFrame(input bit m8, input bit strict);
    exp_flags = '0;
    exp_cnt   = 0;
    for (int r = 0; r < M; r++) begin
      for (int c = 0; c < N; c++) begin
        bit is_max;
        is_max = 1'b1;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr;
            int cc;
            int p;
            int q;
            rr = r + dr;
            cc = c + dc;
            if (dr == 0 && dc == 0) continue;
            if (!m8 && dr != 0 && dc != 0) continue;
            if (rr < 0 || rr >= M || cc < 0 || cc >= N) continue;
            p = int'(frame[r*N+c]);
            q = int'(frame[rr*N+cc]);
            if (strict ? !(p > q) : !(p >= q)) is_max = 1'b0;
          end
        end
        exp_flags[r*N+c] = is_max;
        exp_cnt += int'(is_max);
      end
    end
  endtask

  // Runs one frame. Returns after done has been seen (plus a few idle cycles),
  // after an abort, or when the cycle budget runs out.
  task automatic applyStimulus(input bit m8, input bit strict, input int ready_pct,
                               input int valid_pct, input int abort_after, input int restart_at);
    int  acc;
    int  cyc;
    int  extra;
    bit  prev_stall;
    bit  prev_max;
    bit  prev_last;
    bit  restart_done;
    got_flags = '0;
    got_last  = '0;
    n_flags   = 0;
    n_done    = 0;
    n_bad     = 0;
    timed_out = 1'b0;
    @(negedge clk);
    start       = 1'b1;
    mode_8conn  = m8;
    mode_strict = strict;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    mode_8conn   = ~m8;
    mode_strict  = ~strict;
    acc          = 0;
    cyc          = 0;
    extra        = 0;
    prev_stall   = 1'b0;
    prev_max     = 1'b0;
    prev_last    = 1'b0;
    restart_done = 1'b0;
    while (cyc < 600 && extra < 4) begin
      in_valid  = ($urandom_range(99) < valid_pct);
      pixel_in  = (acc < TOTAL) ? frame[acc] : PW'($urandom);
      out_ready = ($urandom_range(99) < ready_pct);
      start     = 1'b0;
      if (restart_at >= 0 && acc == restart_at && !restart_done) begin
        start        = 1'b1;
        restart_done = 1'b1;
      end
      #1;
      if (prev_stall && !(out_valid && out_max == prev_max && out_last == prev_last)) n_bad++;
      if (out_valid && !out_ready && in_ready) n_bad++;
      if (done) n_done++;
      if (out_valid && out_ready) begin
        if (n_flags < TOTAL) begin
          got_flags[n_flags] = out_max;
          got_last[n_flags]  = out_last;
        end
        n_flags++;
      end
      if (in_valid && in_ready) begin
        if (acc >= TOTAL) n_bad++;
        else acc++;
      end
      prev_stall = out_valid && !out_ready;
      prev_max   = out_max;
      prev_last  = out_last;
      if (abort_after >= 0 && acc == abort_after && in_valid && in_ready) begin
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_in_ready", 32'(in_ready), 32'd0);
        checkOutput("abort_max_count", 32'(max_count), 32'd0);
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) begin
          @(negedge clk);
          #1;
          if (done) n_done++;
        end
        checkOutput("abort_no_done", 32'(n_done), 32'd0);
        return;
      end
      if (n_done > 0) extra++;
      @(negedge clk);
      cyc++;
    end
    timed_out = (extra < 4);
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic checkFrame(input string tag);
    checkOutput({tag, "_timeout"}, 32'(timed_out), 32'd0);
    checkOutput({tag, "_flags"}, 32'(got_flags), 32'(exp_flags));
    checkOutput({tag, "_last"}, 32'(got_last), 32'h8000);
    checkOutput({tag, "_nflags"}, 32'(n_flags), 32'(TOTAL));
    checkOutput({tag, "_done"}, 32'(n_done), 32'd1);
    checkOutput({tag, "_count"}, 32'(max_count), 32'(exp_cnt));
    checkOutput({tag, "_stall"}, 32'(n_bad), 32'd0);
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset values
    #12;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_max", 32'(out_max), 32'd0);
    checkOutput("rst_out_last", 32'(out_last), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_max_count", 32'(max_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Ascending ramp, 8-neighbour strict: only the bottom-right pixel wins
    for (int k = 0; k < TOTAL; k++) frame[k] = PW'(k);
    applyStimulus(1'b1, 1'b1, 100, 100, -1, -1);
    modelFrame(1'b1, 1'b1);
    checkFrame("asc");
    checkOutput("asc_const_flags", 32'(got_flags), 32'h8000);
    checkOutput("asc_const_count", 32'(max_count), 32'd1);

    // Flat frame in strict and non-strict modes
    for (int k = 0; k < TOTAL; k++) frame[k] = PW'(7);
    applyStimulus(1'b1, 1'b1, 100, 100, -1, -1);
    modelFrame(1'b1, 1'b1);
    checkFrame("flat_strict");
    checkOutput("flat_strict_const", 32'(max_count), 32'd0);
    applyStimulus(1'b1, 1'b0, 100, 100, -1, -1);
    modelFrame(1'b1, 1'b0);
    checkFrame("flat_nonstrict");
    checkOutput("flat_nonstrict_const", 32'(got_flags), 32'hFFFF);

    // Checkerboard 9/1: 4-neighbour finds all 9s, 8-neighbour finds none
    for (int k = 0; k < TOTAL; k++) frame[k] = (((k / N) + (k % N)) % 2 == 0) ? PW'(9) : PW'(1);
    applyStimulus(1'b0, 1'b1, 100, 100, -1, -1);
    modelFrame(1'b0, 1'b1);
    checkFrame("chk4");
    checkOutput("chk4_const", 32'(max_count), 32'd8);
    applyStimulus(1'b1, 1'b1, 100, 100, -1, -1);
    modelFrame(1'b1, 1'b1);
    checkFrame("chk8");
    checkOutput("chk8_const", 32'(got_flags), 32'd0);

    // Single peak: a 50% output stall must not change the flags
    for (int k = 0; k < TOTAL; k++) frame[k] = '0;
    frame[1*N+2] = PW'(200);
    applyStimulus(1'b1, 1'b1, 100, 100, -1, -1);
    saved_flags = got_flags;
    applyStimulus(1'b1, 1'b1, 50, 100, -1, -1);
    modelFrame(1'b1, 1'b1);
    checkFrame("peak_stall");
    checkOutput("peak_vs_nostall", 32'(got_flags), 32'(saved_flags));
    checkOutput("peak_const", 32'(got_flags), 32'h0040);

    // Abort after 6 accepted pixels, then a clean ascending frame
    for (int k = 0; k < TOTAL; k++) frame[k] = PW'(k);
    applyStimulus(1'b1, 1'b1, 100, 100, 6, -1);
    applyStimulus(1'b1, 1'b1, 100, 100, -1, -1);
    modelFrame(1'b1, 1'b1);
    checkFrame("post_abort");

    // Random frames with a mid-frame start pulse and flipped mode inputs
    for (int f = 0; f < 1000; f++) begin
      bit m8;
      bit st;
      m8 = 1'($urandom_range(1));
      st = 1'($urandom_range(1));
      for (int k = 0; k < TOTAL; k++) frame[k] = PW'($urandom_range(3));
      applyStimulus(m8, st, 70, 70, -1, int'($urandom_range(12, 2)));
      modelFrame(m8, st);
      checkFrame("rnd");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/eda_local_max_stream.md
Name: eda_local_max_stream

Overview:
- Streaming successor to eda_regional_max: no image RAM, no full-frame matrix_output.
- Accepts an M x N frame as a raster pixel stream over a valid/ready handshake.
- Emits one local-maximum flag per pixel, in raster order, over a valid/ready output with backpressure.
- Runtime selection of 4- or 8-connectivity and strict or non-strict comparison; counts maxima per frame.

Parameters:
M, 8, frame rows (>=2)
N, 8, frame columns (>=2)
PIXEL_WIDTH, 8, pixel bit width
CNT_WIDTH, $clog2(M*N+1), width of max_count

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; starts a frame and latches mode inputs
mode_8conn  in  1  1 = 8-neighbour comparison, 0 = 4-neighbour
mode_strict  in  1  1 = pixel must be > every neighbour; 0 = >= every neighbour
in_valid  in  1  pixel_in valid
in_ready  out  1  block accepts pixel this cycle
pixel_in  in  PIXEL_WIDTH  raster-order pixel
out_valid  out  1  out_max valid
out_ready  in  1  downstream accepts
out_max  out  1  1 = pixel is a local maximum
out_last  out  1  marks flag of pixel (M-1,N-1)
done  out  1  one-cycle pulse at frame completion
max_count  out  CNT_WIDTH  number of 1 flags in the last completed frame
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; in_ready, out_valid, out_max, out_last, done, busy = 0; max_count = 0; row/col counters = 0.
- FSM states: IDLE, STREAM, FLUSH, DONE.
- IDLE: on start, latch mode_8conn and mode_strict, clear the internal counter, go to STREAM. max_count keeps its previous value until DONE.
- STREAM: in_ready = !out_valid || out_ready. An accepted pixel is a cycle with in_valid && in_ready.
  - After the last pixel (index M*N-1) is accepted, go to FLUSH.
- Ordering and latency: the flag for pixel index k (k = r*N + c) is loaded into the output register in the cycle the pixel with index k+N+1 is accepted.
  - STREAM therefore produces M*N-N-1 flags.
  - FLUSH produces the remaining N+1 flags, one per cycle whenever the output register is free or drained (!out_valid || out_ready).
  - in_ready = 0 in FLUSH.
- Output register: out_valid, out_max and out_last stay stable while out_valid && !out_ready. No flag is dropped or duplicated.
- Neighbour set:
  - 4-connectivity: N, S, E, W.
  - 8-connectivity: additionally NE, NW, SE, SW.
  - Neighbours outside the frame are excluded: border pixels compare only with in-frame neighbours. There is no padding and no wrap-around across row ends.
- Comparison: unsigned. Strict mode: pixel > all neighbours. Non-strict mode: pixel >= all neighbours, so a flat frame is all 1.
- Count: max_count accumulator increments on each out handshake with out_max = 1. The internal counter is copied to max_count when out_last is handshaken.
- DONE: entered on the out_last handshake. done = 1 for exactly that one cycle, then return to IDLE.
- start while busy: ignored, with no effect on modes or counters.
- Mode inputs are sampled only at start; changes mid-frame are ignored.
- in_valid outside STREAM: ignored, in_ready = 0.
- Asynchronous reset mid-frame: immediate return to reset values. The partial frame is discarded and no done is issued.

Test Plan:
- M=N=4, PW=8, frame 0..15 raster ascending, 8-conn, strict.
  - Expect only pixel (3,3) = 1, out_last on the 16th flag, done pulse, max_count = 1.
- Same frame, all pixels 7.
  - Strict: 16 zeros, max_count = 0.
  - Non-strict: 16 ones, max_count = 16.
- Checkerboard 9/1 (9 where r+c is even).
  - 4-conn strict: flag = 1 exactly at the eight 9s, max_count = 8.
  - 8-conn strict: all 0, because diagonal 9s tie.
- Single 200 at (1,2), all others 0, out_ready toggled randomly 50%.
  - Flags identical to the no-stall run.
  - in_ready low whenever the output is stalled.
  - Exactly 16 flags; done appears once.
- Reset asserted after 6 accepted pixels, then a new start with the ascending frame.
  - No done for the aborted frame; the new frame gives max_count = 1.
- start pulsed mid-frame with different modes.
  - Modes and results unchanged; compare against a reference model over 1000 random frames.
